// File: rtl/decode_stage_sb.sv
// RV32I decode stage: holds one fetched instruction, decodes every base format,
// tracks in-flight destinations in a scoreboard and issues into a registered slot.
module decode_stage_sb #(
  parameter int BITSIZE   = 32,
  parameter int PC_ADJUST = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               flush_i,
  output logic               inv_instr_o,
  input  logic               IF_ID_give_i,
  output logic               ID_IF_get_o,
  input  logic [31:0]        IF_ID_instr_i,
  input  logic [BITSIZE-1:0] IF_ID_pc_i,
  input  logic               EX_ID_get_i,
  output logic               ID_EX_give_o,
  output logic [31:0]        ID_EX_instruction_o,
  output logic [BITSIZE-1:0] ID_EX_pc_o,
  output logic [BITSIZE-1:0] ID_EX_rs1_o,
  output logic [BITSIZE-1:0] ID_EX_rs2_o,
  output logic [BITSIZE-1:0] ID_EX_imm_o,
  output logic [4:0]         ID_EX_rd_o,
  output logic [4:0]         ID_REG_rs1_o,
  output logic [4:0]         ID_REG_rs2_o,
  input  logic [BITSIZE-1:0] REG_ID_rs1_d_i,
  input  logic [BITSIZE-1:0] REG_ID_rs2_d_i,
  input  logic               WB_ID_valid_i,
  input  logic [4:0]         WB_ID_rd_i
);

  generate
    if (BITSIZE < 32) begin : g_bitsize_chk
      $error("decode_stage_sb: BITSIZE must be >= 32");
    end
  endgenerate

  localparam logic [0:0] ST_GET    = 1'b0;
  localparam logic [0:0] ST_DECODE = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [BITSIZE-1:0] PC_ADJ = BITSIZE'(PC_ADJUST);

  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [BITSIZE-1:0] sext(input logic signed [31:0] v);
    logic signed [BITSIZE-1:0] r;
    r       = {BITSIZE{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [0:0]          state_p0;
  logic [31:0]         instr_p0;
  logic [BITSIZE-1:0]  pc_p0;

  logic                vld_p1;
  logic [31:0]         instr_p1;
  logic [BITSIZE-1:0]  pc_p1;
  logic [BITSIZE-1:0]  rs1_p1;
  logic [BITSIZE-1:0]  rs2_p1;
  logic signed [BITSIZE-1:0] imm_p1;
  logic [4:0]          rd_p1;
  logic                inv_p1;

  logic [31:0]         sb_q;
  logic [31:0]         sb_nxt;

  logic [6:0]          opcode;
  logic [4:0]          rs1_f;
  logic [4:0]          rs2_f;
  logic [4:0]          rd_f;
  logic                op_valid;
  logic                use_rs1;
  logic                use_rs2;
  logic                use_rd;
  logic signed [31:0]  imm32;

  logic                in_decode;
  logic                busy1;
  logic                busy2;
  logic                issue;
  logic                drop;
  logic                capture;
  logic                out_hs;

  assign opcode = instr_p0[6:0];
  assign rs1_f  = instr_p0[19:15];
  assign rs2_f  = instr_p0[24:20];
  assign rd_f   = instr_p0[11:7];

  always_comb begin
    op_valid = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    imm32    = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1;
        imm32  = imm_u(instr_p0);
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        imm32  = imm_j(instr_p0);
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = imm_i(instr_p0);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_s(instr_p0);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_b(instr_p0);
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        op_valid = 1'b1;
      end
      default: op_valid = 1'b0;
    endcase
  end

  assign in_decode = (state_p0 == ST_DECODE);

  // A source is also busy when the instruction still waiting in the output slot writes it.
  assign busy1 = use_rs1 && (rs1_f != 5'd0) &&
                 (sb_q[rs1_f] || (vld_p1 && (rd_p1 == rs1_f)));
  assign busy2 = use_rs2 && (rs2_f != 5'd0) &&
                 (sb_q[rs2_f] || (vld_p1 && (rd_p1 == rs2_f)));

  assign out_hs  = vld_p1 && EX_ID_get_i;
  assign issue   = in_decode && op_valid && !busy1 && !busy2 &&
                   (!vld_p1 || EX_ID_get_i) && !flush_i;
  assign drop    = in_decode && !op_valid && !flush_i;
  assign capture = !in_decode && IF_ID_give_i && !flush_i;

  assign ID_IF_get_o  = !in_decode;
  assign ID_REG_rs1_o = (in_decode && use_rs1) ? rs1_f : 5'd0;
  assign ID_REG_rs2_o = (in_decode && use_rs2) ? rs2_f : 5'd0;

  // Stage p0: IF handshake into the held instruction register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_p0 <= ST_GET;
      instr_p0 <= '0;
      pc_p0    <= '0;
    end else if (flush_i) begin
      state_p0 <= ST_GET;
    end else if (capture) begin
      state_p0 <= ST_DECODE;
      instr_p0 <= IF_ID_instr_i;
      pc_p0    <= IF_ID_pc_i;
    end else if (issue || drop) begin
      state_p0 <= ST_GET;
    end
  end

  // Stage p1: registered output slot towards EX
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      imm_p1   <= '0;
      rd_p1    <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (issue) begin
      vld_p1   <= 1'b1;
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0 - PC_ADJ;
      rs1_p1   <= use_rs1 ? REG_ID_rs1_d_i : '0;
      rs2_p1   <= use_rs2 ? REG_ID_rs2_d_i : '0;
      imm_p1   <= sext(imm32);
      rd_p1    <= use_rd ? rd_f : 5'd0;
    end else if (out_hs) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      inv_p1 <= 1'b0;
    end else begin
      inv_p1 <= drop;
    end
  end

  // Set is applied after clear so a same-cycle issue of rd wins over its writeback.
  always_comb begin
    sb_nxt = sb_q;
    if (WB_ID_valid_i && (WB_ID_rd_i != 5'd0)) begin
      sb_nxt[WB_ID_rd_i] = 1'b0;
    end
    if (out_hs && !flush_i && (rd_p1 != 5'd0)) begin
      sb_nxt[rd_p1] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_nxt;
    end
  end

  assign inv_instr_o         = inv_p1;
  assign ID_EX_give_o        = vld_p1;
  assign ID_EX_instruction_o = instr_p1;
  assign ID_EX_pc_o          = pc_p1;
  assign ID_EX_rs1_o         = rs1_p1;
  assign ID_EX_rs2_o         = rs2_p1;
  assign ID_EX_imm_o         = imm_p1;
  assign ID_EX_rd_o          = rd_p1;

endmodule
